// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the SRAM transaction controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } sram_ctrl_state_e;

    // Width of a counter that must reach max(cols, read_wait).
    function automatic int ctr_width(input int cols, input int read_wait);
        int m;
        m = (cols > read_wait) ? cols : read_wait;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_ser.sv
// MSB-first serialiser feeding the SRAM macro SIPO.
// bit_out comes straight from a flop, so it is a registered output; once
// the word has been shifted out the register holds zero, so bit_out idles low.
module sram_ctrl_ser
    import sram_ctrl_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [COLS-1:0] wdata,
    output logic            busy,
    output logic            bit_out,
    output logic            last
);

    localparam int CW = ctr_width(COLS, 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(COLS - 1);

    logic [COLS-1:0] sreg_r;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;

    // Load the word, then shift one bit per cycle until the last bit has been presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_r <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (load) begin
            sreg_r <= wdata;
            cnt_r  <= '0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            sreg_r <= sreg_r << 1;
            if (cnt_r == LAST_BIT) begin
                cnt_r  <= '0;
                busy_r <= 1'b0;
            end else begin
                cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            sreg_r <= sreg_r;
            cnt_r  <= cnt_r;
            busy_r <= busy_r;
        end
    end

    assign busy    = busy_r;
    assign bit_out = sreg_r[COLS-1];
    assign last    = busy_r && (cnt_r == LAST_BIT);

endmodule

// File: rtl/sram_ctrl.sv
// Transaction controller in front of the mixed-signal SRAM macro.
// Accepts one read or write at a time, serialises write data, pulses
// w_en, times the sense window and returns a one-cycle response.
// Optional feature: define SRAM_CTRL_READBACK_EN to read every written
// word back and flag a mismatch in rsp_err.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int READ_WAIT = 2,
    localparam int AW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [COLS-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [COLS-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            sram_serial_in,
    output logic            sram_shift,
    output logic            sram_w_en,
    output logic            sram_r_en,
    output logic [AW-1:0]   sram_addr,
    input  logic            sram_data_valid,
    input  logic [COLS-1:0] sram_data_out
);

    localparam int CW = ctr_width(COLS, READ_WAIT);
    localparam logic [CW-1:0] RD_LAST = CW'(READ_WAIT - 1);

    sram_ctrl_state_e state_r;
    sram_ctrl_state_e state_nx_s;

    logic [CW-1:0]   rd_cnt_r;
    logic            req_ready_r;
    logic            w_en_r;
    logic            r_en_r;
    logic            rsp_valid_r;
    logic            rsp_err_r;
    logic [AW-1:0]   addr_r;
    logic [COLS-1:0] rsp_rdata_r;

    logic accept_s;
    logic addr_bad_s;
    logic load_s;
    logic rd_last_s;
    logic rd_err_s;
    logic ser_busy_s;
    logic ser_bit_s;
    logic ser_last_s;

    assign accept_s  = req_valid && (state_r == IDLE);
    assign rd_last_s = (rd_cnt_r == RD_LAST);

    // Out-of-range rows can only exist when ROWS is not a power of two.
    generate
        if (ROWS == (1 << AW)) begin : g_addr_full
            assign addr_bad_s = 1'b0;
        end else begin : g_addr_chk
            assign addr_bad_s = ({1'b0, req_addr} >= (AW+1)'(ROWS));
        end
    endgenerate

`ifdef SRAM_CTRL_READBACK_EN
    logic [COLS-1:0] wdata_r;
    logic            we_r;

    // Keep the written word so the readback can be compared against it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_r <= '0;
            we_r    <= 1'b0;
        end else if (accept_s) begin
            wdata_r <= req_wdata;
            we_r    <= req_we;
        end else begin
            wdata_r <= wdata_r;
            we_r    <= we_r;
        end
    end

    assign rd_err_s = ~sram_data_valid | (we_r & (sram_data_out != wdata_r));
`else
    assign rd_err_s = ~sram_data_valid;
`endif

    // Next-state decode; a write only loads the serialiser for a valid row.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (addr_bad_s) begin
                        state_nx_s = DONE;
                    end else if (req_we) begin
                        state_nx_s = SHIFT;
                        load_s     = 1'b1;
                    end else begin
                        state_nx_s = READ;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (ser_last_s) begin
                    state_nx_s = WRITE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            WRITE: begin
`ifdef SRAM_CTRL_READBACK_EN
                state_nx_s = READ;
`else
                state_nx_s = DONE;
`endif
            end
            READ: begin
                if (rd_last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = READ;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and strobes registered from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            w_en_r      <= 1'b0;
            r_en_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            req_ready_r <= (state_nx_s == IDLE);
            w_en_r      <= (state_nx_s == WRITE);
            r_en_r      <= (state_nx_s == READ);
            rsp_valid_r <= (state_nx_s == DONE);
        end
    end

    // Row address is held for the whole transaction and parked at zero in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= '0;
        end else if (accept_s && !addr_bad_s) begin
            addr_r <= req_addr;
        end else if (state_nx_s == IDLE) begin
            addr_r <= '0;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Sense-settle counter, running only while in READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_r <= '0;
        end else if ((state_r == READ) && !rd_last_s) begin
            rd_cnt_r <= rd_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            rd_cnt_r <= '0;
        end
    end

    // Response payload: sampled at the end of the read window, cleared after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else if ((state_r == READ) && rd_last_s) begin
            rsp_rdata_r <= sram_data_out;
            rsp_err_r   <= rd_err_s;
        end else if (accept_s && addr_bad_s) begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b1;
        end else if (state_r == DONE) begin
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_rdata_r <= rsp_rdata_r;
            rsp_err_r   <= rsp_err_r;
        end
    end

    sram_ctrl_ser #(
        .COLS (COLS)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .wdata   (req_wdata),
        .busy    (ser_busy_s),
        .bit_out (ser_bit_s),
        .last    (ser_last_s)
    );

    assign req_ready      = req_ready_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_rdata      = rsp_rdata_r;
    assign rsp_err        = rsp_err_r;
    assign sram_serial_in = ser_bit_s;
    assign sram_shift     = ser_busy_s;
    assign sram_w_en      = w_en_r;
    assign sram_r_en      = r_en_r;
    assign sram_addr      = addr_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural SRAM macro model.
// Also exercises a ROWS=6 instance for out-of-range addresses.
// Build with SRAM_CTRL_READBACK_EN to cover the readback variant.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_READBACK_EN
    localparam int         WR_LAT   = 12;
    localparam logic [7:0] WR_RDATA = 8'hA5;
    localparam int         T4_REN   = 4;
`else
    localparam int         WR_LAT   = 10;
    localparam logic [7:0] WR_RDATA = 8'h00;
    localparam int         T4_REN   = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [2:0] req_addr = 3'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       sram_serial_in, sram_shift, sram_w_en, sram_r_en;
    logic [2:0] sram_addr;
    logic       sram_data_valid;
    logic [7:0] sram_data_out;

    logic       req6_valid = 1'b0;
    logic       req6_ready;
    logic       req6_we = 1'b0;
    logic [2:0] req6_addr = 3'd0;
    logic [7:0] req6_wdata = 8'h00;
    logic       rsp6_valid;
    logic [7:0] rsp6_rdata;
    logic       rsp6_err;
    logic       serial6, shift6, w_en6, r_en6;
    logic [2:0] sram_addr6;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    // Free-running cycle number, bumped on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    sram_ctrl u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_serial_in(sram_serial_in), .sram_shift(sram_shift),
        .sram_w_en(sram_w_en), .sram_r_en(sram_r_en), .sram_addr(sram_addr),
        .sram_data_valid(sram_data_valid), .sram_data_out(sram_data_out)
    );

    sram_ctrl #(.ROWS(6)) u_dut6 (
        .clk(clk), .rst(rst),
        .req_valid(req6_valid), .req_ready(req6_ready), .req_we(req6_we),
        .req_addr(req6_addr), .req_wdata(req6_wdata),
        .rsp_valid(rsp6_valid), .rsp_rdata(rsp6_rdata), .rsp_err(rsp6_err),
        .sram_serial_in(serial6), .sram_shift(shift6),
        .sram_w_en(w_en6), .sram_r_en(r_en6), .sram_addr(sram_addr6),
        .sram_data_valid(1'b1), .sram_data_out(8'hFF)
    );

    // SRAM macro model: SIPO, write driver, cell array with optional stuck-at-0 on bit 2.
    logic [7:0] mem [8];
    logic [7:0] sipo;
    logic       stuck2 = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            sipo <= 8'h00;
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
        end else begin
            if (sram_shift) sipo <= {sipo[6:0], sram_serial_in};
            if (sram_w_en)  mem[sram_addr] <= sipo;
        end
    end

    assign sram_data_valid = sram_r_en;
    assign sram_data_out   = sram_r_en ? (mem[sram_addr] & (stuck2 ? 8'hFB : 8'hFF)) : 8'h00;

    // Event monitor sampled on the falling edge.
    int         acc_cnt, acc1, acc2;
    int         shift_cnt, shift_first;
    int         wen_cnt, wen_cyc;
    int         ren_cnt, ren_first;
    int         rsp_cnt, rsp_cyc;
    logic [7:0] ser_bits, rsp_d;
    logic       rsp_e;
    logic [2:0] wen_addr;

    always @(negedge clk) begin
        if (req_valid && req_ready && !rst) begin
            if (acc_cnt == 0) acc1 = cyc;
            if (acc_cnt == 1) acc2 = cyc;
            acc_cnt++;
        end
        if (sram_shift) begin
            if (shift_cnt == 0) shift_first = cyc;
            shift_cnt++;
            ser_bits = {ser_bits[6:0], sram_serial_in};
        end
        if (sram_w_en) begin
            wen_cnt++;
            wen_cyc  = cyc;
            wen_addr = sram_addr;
        end
        if (sram_r_en) begin
            if (ren_cnt == 0) ren_first = cyc;
            ren_cnt++;
        end
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_d   = rsp_rdata;
            rsp_e   = rsp_err;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        acc_cnt = 0; acc1 = 0; acc2 = 0;
        shift_cnt = 0; shift_first = 0;
        wen_cnt = 0; wen_cyc = 0; wen_addr = 3'd0;
        ren_cnt = 0; ren_first = 0;
        rsp_cnt = 0; rsp_cyc = 0;
        ser_bits = 8'h00; rsp_d = 8'h00; rsp_e = 1'b0;
    endtask

    // Present a request and return at the falling edge of its accept cycle.
    task automatic issue(input logic we, input logic [2:0] addr, input logic [7:0] wd);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #2;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (rsp_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic drop_valid();
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    initial begin
        bit         act;
        int         rc;
        logic [7:0] rd6;
        logic       er6;

        clear_mon();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_strobes", {sram_shift, sram_w_en, sram_r_en, sram_serial_in, rsp_valid, rsp_err}, 0);
        check_eq("rst_addr", sram_addr, 0);
        check_eq("rst_rdata", rsp_rdata, 0);

        // 1: reset during SHIFT aborts with no write and no response.
        clear_mon();
        issue(1'b1, 3'd3, 8'hA5);
        drop_valid();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check_eq("t1_ready_after_rst", req_ready, 1);
        check_eq("t1_shift_off", sram_shift, 0);
        repeat (12) @(negedge clk);
        #1;
        check_eq("t1_shift_cycles", shift_cnt, 4);
        check_eq("t1_no_wen", wen_cnt, 0);
        check_eq("t1_no_rsp", rsp_cnt, 0);

        // 2: write 0xA5 to row 3.
        clear_mon();
        issue(1'b1, 3'd3, 8'hA5);
        drop_valid();
        wait_rsp(1);
        repeat (3) @(negedge clk);
        #1;
        check_eq("t2_shift_first", shift_first - acc1, 1);
        check_eq("t2_shift_cycles", shift_cnt, 8);
        check_eq("t2_serial", ser_bits, 8'hA5);
        check_eq("t2_wen_cnt", wen_cnt, 1);
        check_eq("t2_wen_cyc", wen_cyc - acc1, 9);
        check_eq("t2_wen_addr", wen_addr, 3'd3);
        check_eq("t2_rsp_cyc", rsp_cyc - acc1, WR_LAT);
        check_eq("t2_err", rsp_e, 0);
        check_eq("t2_rdata", rsp_d, WR_RDATA);
        check_eq("t2_cell", mem[3], 8'hA5);
        check_eq("t2_addr_idle", sram_addr, 0);

        // 3: read row 3 back.
        clear_mon();
        issue(1'b0, 3'd3, 8'h00);
        drop_valid();
        wait_rsp(1);
        repeat (2) @(negedge clk);
        #1;
        check_eq("t3_ren_first", ren_first - acc1, 1);
        check_eq("t3_ren_cnt", ren_cnt, 2);
        check_eq("t3_rsp_cyc", rsp_cyc - acc1, 3);
        check_eq("t3_rdata", rsp_d, 8'hA5);
        check_eq("t3_err", rsp_e, 0);
        check_eq("t3_no_write", shift_cnt + wen_cnt, 0);

        // 4: write 0xFF to row 0, then a read of row 0 held on req_valid throughout.
        clear_mon();
        issue(1'b1, 3'd0, 8'hFF);
        @(posedge clk); #2;
        req_we = 1'b0; req_wdata = 8'h00;
        rc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (acc_cnt >= 2) break;
            rc++;
        end
        if (rc >= 40) check_eq("t4_accept_timeout", 32'd0, 32'd1);
        drop_valid();
        wait_rsp(2);
        repeat (10) @(negedge clk);
        #1;
        check_eq("t4_second_accept", acc2 - acc1, WR_LAT + 1);
        check_eq("t4_accepts", acc_cnt, 2);
        check_eq("t4_rsps", rsp_cnt, 2);
        check_eq("t4_rdata", rsp_d, 8'hFF);
        check_eq("t4_ren_cnt", ren_cnt, T4_REN);
        check_eq("t4_wen_cnt", wen_cnt, 1);

        // 5: ROWS=6 instance, out-of-range read of row 7.
        @(posedge clk); #2;
        req6_valid = 1'b1; req6_we = 1'b0; req6_addr = 3'd7;
        @(negedge clk);
        check_eq("t5_ready", req6_ready, 1);
        @(posedge clk); #2;
        req6_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_rsp_valid", rsp6_valid, 1);
        check_eq("t5_err", rsp6_err, 1);
        check_eq("t5_rdata", rsp6_rdata, 8'h00);
        act = r_en6 | w_en6 | shift6 | serial6 | (sram_addr6 != 3'd0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            act = act | r_en6 | w_en6 | shift6 | serial6 | (sram_addr6 != 3'd0);
            if (k == 2) check_eq("t5_rsp_one_cycle", rsp6_valid, 0);
        end
        check_eq("t5_no_activity", act, 0);

        // 5b: ROWS=6 instance, highest legal row 5 reads normally.
        @(posedge clk); #2;
        req6_valid = 1'b1; req6_we = 1'b0; req6_addr = 3'd5;
        @(negedge clk);
        check_eq("t5b_ready", req6_ready, 1);
        @(posedge clk); #2;
        req6_valid = 1'b0;
        rc = 0; rd6 = 8'h00; er6 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (rsp6_valid && rc == 0) begin
                rc = k; rd6 = rsp6_rdata; er6 = rsp6_err;
            end
        end
        check_eq("t5b_rsp_cyc", rc, 3);
        check_eq("t5b_rdata", rd6, 8'hFF);
        check_eq("t5b_err", er6, 0);

`ifdef SRAM_CTRL_READBACK_EN
        // 6: readback catches a cell stuck at 0 on bit 2.
        stuck2 = 1'b1;
        clear_mon();
        issue(1'b1, 3'd1, 8'h3C);
        drop_valid();
        wait_rsp(1);
        check_eq("t6_rsp_cyc", rsp_cyc - acc1, 12);
        check_eq("t6_err", rsp_e, 1);
        check_eq("t6_rdata", rsp_d, 8'h38);
        stuck2 = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
